// File: rtl/plot_burst_monitor.sv
// Groups consecutive plot cycles of the pixel stream into bursts and reports each burst's
// bounding box, pixel count and colour summary over a valid/ready handshake.
module plot_burst_monitor #(
   parameter int CNT_W   = 12,
   parameter int GAP_CYC = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [6:0]       in_x,
   input  logic [6:0]       in_y,
   input  logic [2:0]       in_colour,
   input  logic             plot,
   input  logic             rpt_ready,
   output logic             rpt_valid,
   output logic [6:0]       min_x,
   output logic [6:0]       max_x,
   output logic [6:0]       min_y,
   output logic [6:0]       max_y,
   output logic [CNT_W-1:0] pix_count,
   output logic [2:0]       first_col,
   output logic             mixed_col,
   output logic             erase,
   output logic             overflow
);

   typedef enum logic [1:0] {IDLE, ACCUM, GAP} state_t;

   localparam logic [3:0]       GAP_LAST = 4'(GAP_CYC);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state, state_nx;
   logic [3:0]       gap_cnt, gap_cnt_nx;
   logic             start_burst, add_pixel, complete;

   logic [6:0]       acc_min_x, acc_max_x, acc_min_y, acc_max_y;
   logic [CNT_W-1:0] acc_count;
   logic [2:0]       acc_first;
   logic             acc_mixed, acc_erase;

   // NOTE: every signal written here gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_nx    = state;
      gap_cnt_nx  = gap_cnt;
      start_burst = 1'b0;
      add_pixel   = 1'b0;
      complete    = 1'b0;
      case (state)
         IDLE: begin
            if (plot) begin
               start_burst = 1'b1;
               state_nx    = ACCUM;
            end
         end
         ACCUM: begin
            if (plot) begin
               add_pixel = 1'b1;
            end else if (GAP_CYC == 1) begin
               complete = 1'b1;
               state_nx = IDLE;
            end else begin
               state_nx   = GAP;
               gap_cnt_nx = 4'd1;
            end
         end
         GAP: begin
            if (plot) begin
               add_pixel = 1'b1;
               state_nx  = ACCUM;
            end else if (gap_cnt + 4'd1 == GAP_LAST) begin
               complete = 1'b1;
               state_nx = IDLE;
            end else begin
               gap_cnt_nx = gap_cnt + 4'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         gap_cnt <= 4'd0;
      end else begin
         state   <= state_nx;
         gap_cnt <= gap_cnt_nx;
      end
   end

   // Accumulators are independent of the report registers, so a new burst can start
   // in the cycle right after completion.
   always_ff @(posedge clock) begin
      if (reset) begin
         acc_min_x <= '0;
         acc_max_x <= '0;
         acc_min_y <= '0;
         acc_max_y <= '0;
         acc_count <= '0;
         acc_first <= '0;
         acc_mixed <= 1'b0;
         acc_erase <= 1'b0;
      end else if (start_burst) begin
         acc_min_x <= in_x;
         acc_max_x <= in_x;
         acc_min_y <= in_y;
         acc_max_y <= in_y;
         acc_count <= CNT_W'(1);
         acc_first <= in_colour;
         acc_mixed <= 1'b0;
         acc_erase <= (in_colour == 3'd0);
      end else if (add_pixel) begin
         if (in_x < acc_min_x) acc_min_x <= in_x;
         if (in_x > acc_max_x) acc_max_x <= in_x;
         if (in_y < acc_min_y) acc_min_y <= in_y;
         if (in_y > acc_max_y) acc_max_y <= in_y;
         if (acc_count != CNT_MAX) acc_count <= acc_count + CNT_W'(1);
         acc_mixed <= acc_mixed | (in_colour != acc_first);
         acc_erase <= acc_erase & (in_colour == 3'd0);
      end
   end

   // A completed burst is dropped, and overflow latched, only if the held report is not
   // being consumed on the same edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         rpt_valid <= 1'b0;
         min_x     <= '0;
         max_x     <= '0;
         min_y     <= '0;
         max_y     <= '0;
         pix_count <= '0;
         first_col <= '0;
         mixed_col <= 1'b0;
         erase     <= 1'b0;
         overflow  <= 1'b0;
      end else if (complete) begin
         if (!rpt_valid || rpt_ready) begin
            rpt_valid <= 1'b1;
            min_x     <= acc_min_x;
            max_x     <= acc_max_x;
            min_y     <= acc_min_y;
            max_y     <= acc_max_y;
            pix_count <= acc_count;
            first_col <= acc_first;
            mixed_col <= acc_mixed;
            erase     <= acc_erase;
         end else begin
            overflow  <= 1'b1;
         end
      end else if (rpt_valid && rpt_ready) begin
         rpt_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_plot_burst_monitor.sv
// Bench for plot_burst_monitor: three instances (GAP_CYC=1, GAP_CYC=3, CNT_W=4) share one
// stimulus stream; a burst-statistics model predicts every instance's report each cycle.
module tb_plot_burst_monitor;

   typedef struct packed {
      logic        valid;
      logic [6:0]  min_x;
      logic [6:0]  max_x;
      logic [6:0]  min_y;
      logic [6:0]  max_y;
      logic [11:0] cnt;
      logic [2:0]  first;
      logic        mixed;
      logic        erase;
      logic        ovf;
   } rpt_t;

   logic       clock, reset, plot, rpt_ready;
   logic [6:0] in_x, in_y;
   logic [2:0] in_colour;

   rpt_t obs [3];
   rpt_t exp_r [3];

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int GC = (k == 1) ? 3 : 1;
      localparam int CW = (k == 2) ? 4 : 12;
      logic          vld, mixed, ers, ovf;
      logic [6:0]    mnx, mxx, mny, mxy;
      logic [CW-1:0] cnt;
      logic [2:0]    fc;

      plot_burst_monitor #(.CNT_W(CW), .GAP_CYC(GC)) u_dut (
         .clock(clock), .reset(reset), .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
         .plot(plot), .rpt_ready(rpt_ready), .rpt_valid(vld), .min_x(mnx), .max_x(mxx),
         .min_y(mny), .max_y(mxy), .pix_count(cnt), .first_col(fc), .mixed_col(mixed),
         .erase(ers), .overflow(ovf)
      );

      assign obs[k] = {vld, mnx, mxx, mny, mxy, 12'(cnt), fc, mixed, ers, ovf};
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
   endtask

   // ---------------- reference model: running burst statistics ----------------
   int m_act [3], m_low [3], m_n [3], m_first [3], m_ndiff [3], m_nnz [3];
   int m_minx [3], m_maxx [3], m_miny [3], m_maxy [3];

   function automatic int gap_of(input int k);
      return (k == 1) ? 3 : 1;
   endfunction

   function automatic int cmax_of(input int k);
      return (k == 2) ? 15 : 4095;
   endfunction

   task automatic model_step(input int k);
      bit done;
      done = 0;
      if (reset) begin
         m_act[k] = 0; m_low[k] = 0; m_n[k] = 0;
         exp_r[k] = '0;
         return;
      end
      if (plot) begin
         if (m_act[k] == 0) begin
            m_minx[k] = in_x; m_maxx[k] = in_x; m_miny[k] = in_y; m_maxy[k] = in_y;
            m_n[k] = 1; m_first[k] = in_colour; m_ndiff[k] = 0;
            m_nnz[k] = (in_colour != 0) ? 1 : 0;
         end else begin
            if (in_x < m_minx[k]) m_minx[k] = in_x;
            if (in_x > m_maxx[k]) m_maxx[k] = in_x;
            if (in_y < m_miny[k]) m_miny[k] = in_y;
            if (in_y > m_maxy[k]) m_maxy[k] = in_y;
            m_n[k]++;
            if (in_colour != m_first[k]) m_ndiff[k]++;
            if (in_colour != 0) m_nnz[k]++;
         end
         m_act[k] = 1;
         m_low[k] = 0;
      end else if (m_act[k] != 0) begin
         m_low[k]++;
         if (m_low[k] == gap_of(k)) begin
            done = 1;
            m_act[k] = 0;
         end
      end
      if (done) begin
         if (!exp_r[k].valid || rpt_ready) begin
            exp_r[k].valid = 1'b1;
            exp_r[k].min_x = 7'(m_minx[k]);
            exp_r[k].max_x = 7'(m_maxx[k]);
            exp_r[k].min_y = 7'(m_miny[k]);
            exp_r[k].max_y = 7'(m_maxy[k]);
            exp_r[k].cnt   = 12'((m_n[k] > cmax_of(k)) ? cmax_of(k) : m_n[k]);
            exp_r[k].first = 3'(m_first[k]);
            exp_r[k].mixed = (m_ndiff[k] != 0);
            exp_r[k].erase = (m_nnz[k] == 0);
         end else begin
            exp_r[k].ovf = 1'b1;
         end
      end else if (exp_r[k].valid && rpt_ready) begin
         exp_r[k].valid = 1'b0;
      end
   endtask

   always @(posedge clock) begin
      for (int k = 0; k < 3; k++) model_step(k);
   end

   always @(negedge clock) begin
      if (cmp_en) begin
         for (int k = 0; k < 3; k++) check($sformatf("report inst%0d", k), obs[k], exp_r[k]);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input logic p, input logic [6:0] x, input logic [6:0] y,
                      input logic [2:0] c);
      @(negedge clock);
      plot = p; in_x = x; in_y = y; in_colour = c;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 7'($urandom), 7'($urandom), 3'($urandom));
   endtask

   task automatic consume();
      rpt_ready = 1'b1;
      idle(1);
      rpt_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1; plot = 1'b0; rpt_ready = 1'b0;
      in_x = '0; in_y = '0; in_colour = '0;
      repeat (2) @(negedge clock);
      for (int k = 0; k < 3; k++) check($sformatf("reset state inst%0d", k), obs[k], 47'd0);
      cmp_en = 1;
      reset  = 1'b0;

      // 900-pixel erase burst
      for (int p = 0; p < 3; p++)
         for (int y = 40; y < 70; y++)
            for (int x = 20; x < 30; x++) cyc(1'b1, 7'(x), 7'(y), 3'd0);
      idle(4);
      check("t1 valid", obs[0].valid, 1);
      check("t1 min_x", obs[0].min_x, 20);
      check("t1 max_x", obs[0].max_x, 29);
      check("t1 min_y", obs[0].min_y, 40);
      check("t1 max_y", obs[0].max_y, 69);
      check("t1 count", obs[0].cnt, 900);
      check("t1 erase", obs[0].erase, 1);
      check("t1 mixed", obs[0].mixed, 0);
      check("t1 sat count cnt4", obs[2].cnt, 15);
      consume();
      check("t1 consumed", obs[0].valid, 0);

      // single pixel with consumer ready
      rpt_ready = 1'b1;
      cyc(1'b1, 7'd5, 7'd7, 3'b100);
      idle(1);
      check("t2 valid before", obs[0].valid, 0);
      idle(1);
      check("t2 valid", obs[0].valid, 1);
      check("t2 min_x", obs[0].min_x, 5);
      check("t2 max_y", obs[0].max_y, 7);
      check("t2 count", obs[0].cnt, 1);
      check("t2 first_col", obs[0].first, 3'b100);
      check("t2 erase", obs[0].erase, 0);
      idle(1);
      check("t2 valid after", obs[0].valid, 0);

      // second burst completes while the first is unconsumed
      rpt_ready = 1'b0;
      cyc(1'b1, 7'd1, 7'd2, 3'd1);
      cyc(1'b1, 7'd3, 7'd4, 3'd1);
      idle(2);
      cyc(1'b1, 7'd60, 7'd60, 3'd7);
      idle(4);
      check("t3 held min_x", obs[0].min_x, 1);
      check("t3 held max_x", obs[0].max_x, 3);
      check("t3 held count", obs[0].cnt, 2);
      check("t3 overflow", obs[0].ovf, 1);
      consume();
      check("t3 valid dropped", obs[0].valid, 0);
      check("t3 overflow sticky", obs[0].ovf, 1);

      // gap length: one burst at GAP_CYC=3, two bursts at GAP_CYC=1
      rpt_ready = 1'b1;
      idle(6);
      cyc(1'b1, 7'd10, 7'd10, 3'd2);
      cyc(1'b1, 7'd11, 7'd10, 3'd2);
      idle(2);
      check("t4 g1 first count", obs[0].cnt, 2);
      check("t4 g1 first valid", obs[0].valid, 1);
      cyc(1'b1, 7'd12, 7'd10, 3'd2);
      idle(2);
      check("t4 g1 second count", obs[0].cnt, 1);
      idle(2);
      check("t4 g3 valid", obs[1].valid, 1);
      check("t4 g3 count", obs[1].cnt, 3);
      idle(2);

      // mixed colours, then saturation
      rpt_ready = 1'b0;
      cyc(1'b1, 7'd0, 7'd0, 3'b010);
      cyc(1'b1, 7'd1, 7'd0, 3'b010);
      cyc(1'b1, 7'd2, 7'd0, 3'b011);
      idle(2);
      check("t5 mixed", obs[0].mixed, 1);
      check("t5 erase", obs[0].erase, 0);
      check("t5 first_col", obs[0].first, 3'b010);
      consume();
      idle(3);
      for (int i = 0; i < 20; i++) cyc(1'b1, 7'(127 - i), 7'(i), 3'd5);
      idle(4);
      check("t5 cnt4 saturated", obs[2].cnt, 15);
      check("t5 g1 count 20", obs[0].cnt, 20);
      check("t5 g1 max_x", obs[0].max_x, 127);
      consume();
      idle(3);

      // reset in the middle of a burst
      cyc(1'b1, 7'd9, 7'd9, 3'd1);
      cyc(1'b1, 7'd8, 7'd9, 3'd1);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) cyc(1'b1, 7'(30 + i), 7'd50, 3'd6);
      idle(2);
      check("t6 valid", obs[0].valid, 1);
      check("t6 count", obs[0].cnt, 4);
      check("t6 overflow cleared", obs[0].ovf, 0);
      consume();

      // randomized bursts, gaps, handshakes and occasional resets
      for (int b = 0; b < 80; b++) begin
         int          len, mode;
         logic [2:0]  base, c;
         len  = $urandom_range(1, 30);
         mode = $urandom_range(0, 2);
         base = 3'($urandom_range(1, 7));
         for (int i = 0; i < len; i++) begin
            c = (mode == 0) ? 3'd0 : (mode == 1) ? base : 3'($urandom);
            rpt_ready = ($urandom_range(0, 2) == 0);
            cyc(1'b1, 7'($urandom), 7'($urandom), c);
         end
         for (int g = 0; g < $urandom_range(1, 5); g++) begin
            rpt_ready = ($urandom_range(0, 2) == 0);
            idle(1);
         end
         if ($urandom_range(0, 19) == 0) begin
            reset = 1'b1;
            idle(1);
            reset = 1'b0;
         end
      end
      rpt_ready = 1'b1;
      idle(6);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
